// File: rtl/cpu_types_pkg.sv
// Shared datapath/control types for the 5-stage MIPS core.
// Hazard FSM states, forwarding selects and latch-control bundles.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } hazard_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_t;

    // Per-cycle latch controls, PC first, flushes last.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_NONE   = 8'b00000_000;
    localparam pipe_ctl_t CTL_GO     = 8'b11111_000;
    localparam pipe_ctl_t CTL_FREEZE = 8'b00000_001;
    localparam pipe_ctl_t CTL_HALT   = 8'b01111_110;
    localparam pipe_ctl_t CTL_REDIR  = 8'b11111_110;
    localparam pipe_ctl_t CTL_LDUSE  = 8'b00111_010;
    localparam pipe_ctl_t CTL_IMISS  = 8'b01111_100;
    localparam pipe_ctl_t CTL_DRAIN  = 8'b00001_000;

    // A producer can feed a consumer only if it writes a real register.
    function automatic logic reg_match(
        input logic     we,
        input regbits_t dest,
        input regbits_t src
    );
        return we && (dest != '0) && (dest == src);
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Datapath <-> hazard controller bundle.
// master = datapath side, slave = hazard_controller side.
interface hazard_controller_if;
    import cpu_types_pkg::*;

    logic     ihit;
    logic     dhit;
    logic     mem_req;
    logic     mem_halt;
    regbits_t id_rs;
    regbits_t id_rt;
    regbits_t ex_dest;
    logic     ex_regWrite;
    logic     ex_memRead;
    regbits_t mem_dest;
    logic     mem_regWrite;
    logic     ex_pc_redirect;

    logic     pc_en;
    logic     ifid_en;
    logic     idex_en;
    logic     exmem_en;
    logic     memwb_en;
    logic     ifid_flush;
    logic     idex_flush;
    logic     memwb_flush;
    fwd_sel_t fwd_a_sel;
    fwd_sel_t fwd_b_sel;
    logic     halt_done;
    logic     dwait_err;
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;

    modport master (
        output ihit, dhit, mem_req, mem_halt,
        output id_rs, id_rt, ex_dest, ex_regWrite,
        output ex_memRead, mem_dest, mem_regWrite,
        output ex_pc_redirect,
        input  pc_en, ifid_en, idex_en, exmem_en,
        input  memwb_en, ifid_flush, idex_flush,
        input  memwb_flush, fwd_a_sel, fwd_b_sel,
        input  halt_done, dwait_err,
        input  stall_cycles, flush_events
    );

    modport slave (
        input  ihit, dhit, mem_req, mem_halt,
        input  id_rs, id_rt, ex_dest, ex_regWrite,
        input  ex_memRead, mem_dest, mem_regWrite,
        input  ex_pc_redirect,
        output pc_en, ifid_en, idex_en, exmem_en,
        output memwb_en, ifid_flush, idex_flush,
        output memwb_flush, fwd_a_sel, fwd_b_sel,
        output halt_done, dwait_err,
        output stall_cycles, flush_events
    );

endinterface

// File: rtl/hazard_controller_fwd_sel.sv
// Operand forwarding select for one ID/EX source operand.
// The younger EX result always beats MEM; $0 is never forwarded.
module hazard_fwd_sel
    import cpu_types_pkg::*;
(
    input  regbits_t src_i,
    input  regbits_t ex_dest_i,
    input  logic     ex_we_i,
    input  regbits_t mem_dest_i,
    input  logic     mem_we_i,
    output fwd_sel_t sel_o
);

    // Prioritised match: EX, then MEM, else regfile.
    always_comb begin
        sel_o = FWD_RF;
        if (reg_match(ex_we_i, ex_dest_i, src_i)) begin
            sel_o = FWD_EX;
        end else if (reg_match(mem_we_i, mem_dest_i, src_i)) begin
            sel_o = FWD_MEM;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: stalls, bubbles, halt drain, forwarding.
// Optional perf counters built when HAZARD_PERF_EN is defined.
module hazard_controller
    import cpu_types_pkg::*;
#(
    parameter int WAIT_W    = 8,
    parameter int DWAIT_MAX = 200
) (
    input  logic                 CLK,
    input  logic                 RST,
    hazard_controller_if.slave   hif
);

    hazard_state_t     state_q, state_d;
    logic [WAIT_W-1:0] wcnt_q, wcnt_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    pipe_ctl_t rel_ctl;
    pipe_ctl_t ctl;
    logic      dmiss;
    logic      load_use;

    assign dmiss = hif.mem_req && !hif.dhit;

    assign load_use = hif.ex_memRead
                   && (hif.ex_dest != '0)
                   && ((hif.ex_dest == hif.id_rs)
                    || (hif.ex_dest == hif.id_rt));

    // Non-memory rules, shared by RUN and the DWAIT release cycle.
    always_comb begin
        rel_ctl = CTL_GO;
        if (hif.mem_halt) begin
            rel_ctl = CTL_HALT;
        end else if (hif.ex_pc_redirect) begin
            rel_ctl = CTL_REDIR;
        end else if (load_use) begin
            rel_ctl = CTL_LDUSE;
        end else if (!hif.ihit) begin
            rel_ctl = CTL_IMISS;
        end
    end

    // Latch controls by state; everything held low during reset.
    always_comb begin
        ctl = CTL_NONE;
        if (!RST) begin
            unique case (state_q)
                RUN:    ctl = dmiss ? CTL_FREEZE : rel_ctl;
                DWAIT:  ctl = hif.dhit ? rel_ctl : CTL_FREEZE;
                DRAIN:  ctl = CTL_DRAIN;
                HALTED: ctl = CTL_NONE;
                default: ctl = CTL_NONE;
            endcase
        end
    end

    // Next state, wait counter and sticky flags.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        done_d  = done_q;
        unique case (state_q)
            RUN: begin
                if (dmiss) begin
                    state_d = DWAIT;
                    wcnt_d  = WAIT_W'(1);
                end else if (hif.mem_halt) begin
                    state_d = DRAIN;
                end
            end
            DWAIT: begin
                if (hif.dhit) begin
                    wcnt_d  = '0;
                    state_d = hif.mem_halt ? DRAIN : RUN;
                end else if (wcnt_q != '1) begin
                    wcnt_d = wcnt_q + WAIT_W'(1);
                end
            end
            DRAIN: begin
                state_d = HALTED;
                done_d  = 1'b1;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (wcnt_d == WAIT_W'(DWAIT_MAX)) begin
            err_d = 1'b1;
        end
    end

    // FSM and status registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign hif.pc_en       = ctl.pc_en;
    assign hif.ifid_en     = ctl.ifid_en;
    assign hif.idex_en     = ctl.idex_en;
    assign hif.exmem_en    = ctl.exmem_en;
    assign hif.memwb_en    = ctl.memwb_en;
    assign hif.ifid_flush  = ctl.ifid_flush;
    assign hif.idex_flush  = ctl.idex_flush;
    assign hif.memwb_flush = ctl.memwb_flush;
    assign hif.halt_done   = done_q;
    assign hif.dwait_err   = err_q;

    hazard_fwd_sel u_fwd_a (
        .src_i      (hif.id_rs),
        .ex_dest_i  (hif.ex_dest),
        .ex_we_i    (hif.ex_regWrite),
        .mem_dest_i (hif.mem_dest),
        .mem_we_i   (hif.mem_regWrite),
        .sel_o      (hif.fwd_a_sel)
    );

    hazard_fwd_sel u_fwd_b (
        .src_i      (hif.id_rt),
        .ex_dest_i  (hif.ex_dest),
        .ex_we_i    (hif.ex_regWrite),
        .mem_dest_i (hif.mem_dest),
        .mem_we_i   (hif.mem_regWrite),
        .sel_o      (hif.fwd_b_sel)
    );

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // Wrapping perf counters; halted cycles are not stalls.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!ctl.pc_en && state_q != HALTED) begin
                stall_q <= stall_q + 32'd1;
            end
            if (ctl.ifid_flush || ctl.idex_flush) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign hif.stall_cycles = stall_q;
    assign hif.flush_events = flush_q;
`else
    assign hif.stall_cycles = 32'd0;
    assign hif.flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller (DWAIT_MAX=3).
// Table-driven RUN vectors plus hand sequences via a scoreboard queue.
module tb_hazard_controller;
    import cpu_types_pkg::*;

    typedef struct packed {
        logic     ihit;
        logic     dhit;
        logic     mem_req;
        logic     mem_halt;
        regbits_t id_rs;
        regbits_t id_rt;
        regbits_t ex_dest;
        logic     ex_regWrite;
        logic     ex_memRead;
        regbits_t mem_dest;
        logic     mem_regWrite;
        logic     redir;
    } in_t;

    // en: pc,ifid,idex,exmem,memwb  fl: ifid,idex,memwb
    typedef struct packed {
        logic [4:0] en;
        logic [2:0] fl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       hd;
        logic       err;
    } out_t;

    typedef struct {
        in_t   i;
        out_t  e;
        string nm;
    } vec_t;

    typedef struct {
        string nm;
        out_t  e;
    } sb_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    sb_t  sbq[$];
    in_t  IDLE;
    vec_t tbl[13];

    hazard_controller_if hif();

    hazard_controller #(
        .WAIT_W    (8),
        .DWAIT_MAX (3)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .hif (hif)
    );

    always #5 CLK = ~CLK;

    function automatic out_t mko(
        input logic [4:0] en,
        input logic [2:0] fl,
        input logic [1:0] fa,
        input logic [1:0] fb,
        input logic       hd,
        input logic       err
    );
        out_t o;
        o.en  = en;
        o.fl  = fl;
        o.fa  = fa;
        o.fb  = fb;
        o.hd  = hd;
        o.err = err;
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.en  = {hif.pc_en, hif.ifid_en, hif.idex_en,
                 hif.exmem_en, hif.memwb_en};
        o.fl  = {hif.ifid_flush, hif.idex_flush,
                 hif.memwb_flush};
        o.fa  = hif.fwd_a_sel;
        o.fb  = hif.fwd_b_sel;
        o.hd  = hif.halt_done;
        o.err = hif.dwait_err;
        return o;
    endfunction

    task automatic drive(input in_t i);
        hif.ihit           = i.ihit;
        hif.dhit           = i.dhit;
        hif.mem_req        = i.mem_req;
        hif.mem_halt       = i.mem_halt;
        hif.id_rs          = i.id_rs;
        hif.id_rt          = i.id_rt;
        hif.ex_dest        = i.ex_dest;
        hif.ex_regWrite    = i.ex_regWrite;
        hif.ex_memRead     = i.ex_memRead;
        hif.mem_dest       = i.mem_dest;
        hif.mem_regWrite   = i.mem_regWrite;
        hif.ex_pc_redirect = i.redir;
    endtask

    task automatic pop_cmp();
        sb_t  r;
        out_t a;
        if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_empty");
            return;
        end
        r = sbq.pop_front();
        a = sample();
        n_chk++;
        if (a !== r.e) begin
            n_fail++;
            $display("FAIL %s: got %b/%b/%0d/%0d/%b/%b want %b/%b/%0d/%0d/%b/%b",
                     r.nm, a.en, a.fl, a.fa, a.fb, a.hd, a.err,
                     r.e.en, r.e.fl, r.e.fa, r.e.fb, r.e.hd, r.e.err);
        end
    endtask

    task automatic step(input in_t i, input out_t e,
                        input string nm);
        @(posedge CLK);
        #1;
        drive(i);
        sbq.push_back('{nm, e});
        @(negedge CLK);
        pop_cmp();
    endtask

    task automatic chk_now(input out_t e, input string nm);
        sbq.push_back('{nm, e});
        pop_cmp();
    endtask

    task automatic chk32(input string nm, input logic [31:0] a,
                         input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, a, e);
        end
    endtask

    out_t GO, FRZ, Z;
    in_t  v;

    initial begin
        IDLE      = '0;
        IDLE.ihit = 1'b1;
        GO  = mko(5'b11111, 3'b000, 0, 0, 0, 0);
        FRZ = mko(5'b00000, 3'b001, 0, 0, 0, 0);
        Z   = mko(5'b00000, 3'b000, 0, 0, 0, 0);

        for (int k = 0; k < 13; k++) tbl[k].i = IDLE;
        tbl[0].e = GO;  tbl[0].nm = "idle";
        tbl[1].i.ihit = 0;
        tbl[1].e = mko(5'b01111, 3'b100, 0, 0, 0, 0);
        tbl[1].nm = "imiss";
        tbl[2].i.ex_memRead = 1; tbl[2].i.ex_regWrite = 1;
        tbl[2].i.ex_dest = 8;    tbl[2].i.id_rs = 8;
        tbl[2].e = mko(5'b00111, 3'b010, 1, 0, 0, 0);
        tbl[2].nm = "loaduse_rs";
        tbl[3].i.mem_regWrite = 1; tbl[3].i.mem_dest = 8;
        tbl[3].i.id_rs = 8;
        tbl[3].e = mko(5'b11111, 3'b000, 2, 0, 0, 0);
        tbl[3].nm = "loaduse_fwd_mem";
        tbl[4].i.ex_memRead = 1; tbl[4].i.ex_regWrite = 1;
        tbl[4].i.ex_dest = 12;   tbl[4].i.id_rt = 12;
        tbl[4].e = mko(5'b00111, 3'b010, 0, 1, 0, 0);
        tbl[4].nm = "loaduse_rt";
        tbl[5].i.ex_memRead = 1; tbl[5].i.ex_regWrite = 1;
        tbl[5].e = GO;  tbl[5].nm = "loaduse_r0";
        tbl[6].i.ex_memRead = 1; tbl[6].i.ex_regWrite = 1;
        tbl[6].i.ex_dest = 8;    tbl[6].i.id_rs = 8;
        tbl[6].i.redir = 1;
        tbl[6].e = mko(5'b11111, 3'b110, 1, 0, 0, 0);
        tbl[6].nm = "redir_beats_loaduse";
        tbl[7].i.ex_regWrite = 1;  tbl[7].i.ex_dest = 9;
        tbl[7].i.mem_regWrite = 1; tbl[7].i.mem_dest = 9;
        tbl[7].i.id_rt = 9;
        tbl[7].e = mko(5'b11111, 3'b000, 0, 1, 0, 0);
        tbl[7].nm = "double_match";
        tbl[8].i.ex_regWrite = 1;  tbl[8].i.mem_regWrite = 1;
        tbl[8].i.mem_dest = 9;
        tbl[8].e = GO;  tbl[8].nm = "no_fwd_r0";
        tbl[9].i.ex_dest = 5;      tbl[9].i.mem_regWrite = 1;
        tbl[9].i.mem_dest = 5;     tbl[9].i.id_rt = 5;
        tbl[9].e = mko(5'b11111, 3'b000, 0, 2, 0, 0);
        tbl[9].nm = "mem_only_b";
        tbl[10].i.mem_req = 1; tbl[10].i.dhit = 1;
        tbl[10].e = GO; tbl[10].nm = "dhit_access";
        tbl[11].i.ex_memRead = 1; tbl[11].i.ex_regWrite = 1;
        tbl[11].i.ex_dest = 8;    tbl[11].i.id_rs = 8;
        tbl[11].i.ihit = 0;
        tbl[11].e = mko(5'b00111, 3'b010, 1, 0, 0, 0);
        tbl[11].nm = "loaduse_beats_imiss";
        tbl[12].i.redir = 1; tbl[12].i.ihit = 0;
        tbl[12].e = mko(5'b11111, 3'b110, 0, 0, 0, 0);
        tbl[12].nm = "redir_beats_imiss";

        drive(IDLE);
        #2;
        chk_now(Z, "reset_state");
        chk32("reset_stall_cnt", hif.stall_cycles, 32'd0);
        chk32("reset_flush_cnt", hif.flush_events, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        for (int k = 0; k < 13; k++) begin
            step(tbl[k].i, tbl[k].e, tbl[k].nm);
        end

        // D-miss: five frozen cycles, release on dhit.
        v = IDLE;
        v.mem_req = 1;
        for (int k = 1; k <= 5; k++) begin
            FRZ.err = (k >= 4);
            step(v, FRZ, $sformatf("dmiss_c%0d", k));
        end
        v.dhit = 1;
        step(v, mko(5'b11111, 3'b000, 0, 0, 0, 1), "dmiss_release");
        step(IDLE, mko(5'b11111, 3'b000, 0, 0, 0, 1), "err_sticky");

        // Redirect held in EX across a D-miss.
        v = IDLE;
        v.mem_req = 1;
        v.redir = 1;
        FRZ.err = 1;
        step(v, FRZ, "redir_dmiss_c1");
        step(v, FRZ, "redir_dmiss_c2");
        v.dhit = 1;
        step(v, mko(5'b11111, 3'b110, 0, 0, 0, 1), "redir_release");

        // Async reset in the middle of a D-wait.
        v = IDLE;
        v.mem_req = 1;
        step(v, FRZ, "pre_reset_dmiss");
        step(v, FRZ, "pre_reset_dwait");
        #1;
        RST = 1'b1;
        #1;
        chk_now(Z, "async_reset_mid_dwait");
        chk32("rst_stall_cnt", hif.stall_cycles, 32'd0);
        chk32("rst_flush_cnt", hif.flush_events, 32'd0);
        drive(IDLE);
        @(negedge CLK);
        RST = 1'b0;
        step(IDLE, GO, "after_reset_run");

`ifdef HAZARD_PERF_EN
        v = IDLE;
        v.ihit = 0;
        for (int k = 0; k < 3; k++) begin
            step(v, mko(5'b01111, 3'b100, 0, 0, 0, 0), "perf_imiss");
        end
        step(IDLE, GO, "perf_idle");
        chk32("perf_stall_cnt", hif.stall_cycles, 32'd3);
        chk32("perf_flush_cnt", hif.flush_events, 32'd3);
`endif

        // Halt and drain.
        v = IDLE;
        v.mem_halt = 1;
        step(v, mko(5'b01111, 3'b110, 0, 0, 0, 0), "halt_in_mem");
        step(IDLE, mko(5'b00001, 3'b000, 0, 0, 0, 0), "drain");
        for (int k = 0; k < 11; k++) begin
            step(IDLE, mko(5'b00000, 3'b000, 0, 0, 1, 0),
                 $sformatf("halted_%0d", k));
        end
        #1;
        RST = 1'b1;
        #1;
        chk_now(Z, "halt_reset");
        @(negedge CLK);
        RST = 1'b0;
        step(IDLE, GO, "run_after_halt_reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
